// File: rtl/tone_voice_mixer.sv
// Multi-voice square-wave synthesiser mixed into the codec sample stream.
// Define TONE_VOICE_MIXER_SAT_EN to clamp the mix instead of wrapping it.
module tone_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 19,
  parameter int AMP_W      = 24,
  parameter int SAMPLE_W   = 32
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  input  logic [NUM_VOICES*AMP_W-1:0]    voice_amp,
  input  logic                           pass_en,
  input  logic                           audio_in_available,
  input  logic                           audio_out_allowed,
  input  logic [SAMPLE_W-1:0]            left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]            right_channel_audio_in,
  output logic                           read_audio_in,
  output logic                           write_audio_out,
  output logic [SAMPLE_W-1:0]            left_channel_audio_out,
  output logic [SAMPLE_W-1:0]            right_channel_audio_out,
  output logic [NUM_VOICES-1:0]          voice_active
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] tone_q, tone_d, tone_next;
  logic signed [ACC_W-1:0] snap_q [NUM_VOICES];
  logic signed [ACC_W-1:0] snap_d [NUM_VOICES];
  logic signed [ACC_W-1:0] contrib [NUM_VOICES];
  logic [SAMPLE_W-1:0]     in_l_q, in_l_d, in_r_q, in_r_d;
  logic [SAMPLE_W-1:0]     out_l_q, out_l_d, out_r_q, out_r_d;
  logic [SAMPLE_W-1:0]     mix_l, mix_r;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [PERIOD_W-1:0]     period;
    logic [AMP_W-1:0]        amp;
    logic signed [ACC_W-1:0] amp_ext;
    logic                    running;
    logic [PERIOD_W-1:0]     cnt_q, cnt_d;
    logic                    phase_q, phase_d;

    assign period          = voice_period[v*PERIOD_W +: PERIOD_W];
    assign amp             = voice_amp[v*AMP_W +: AMP_W];
    assign amp_ext         = {{(ACC_W-AMP_W){1'b0}}, amp};
    assign running         = voice_en[v] && (period != '0);
    assign voice_active[v] = running;

    // Using >= lets a period shortened below the current count wrap at once.
    always_comb begin
      cnt_d   = '0;
      phase_d = 1'b0;
      if (running) begin
        if (cnt_q >= period) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = cnt_q + PERIOD_W'(1);
          phase_d = phase_q;
        end
      end
    end

    // NOTE: state registers take <= so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
      end
    end

    assign contrib[v] = !running ? '0 : (phase_q ? amp_ext : -amp_ext);
  end

  assign tone_next = tone_q + snap_q[idx_q];

`ifdef TONE_VOICE_MIXER_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic signed [ACC_W-1:0] wide_l, wide_r;

  function automatic logic [SAMPLE_W-1:0] clamp(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX)      clamp = SAT_MAX[SAMPLE_W-1:0];
    else if (x < SAT_MIN) clamp = SAT_MIN[SAMPLE_W-1:0];
    else                  clamp = x[SAMPLE_W-1:0];
  endfunction

  assign wide_l = {{(ACC_W-SAMPLE_W){in_l_q[SAMPLE_W-1]}}, in_l_q} + tone_next;
  assign wide_r = {{(ACC_W-SAMPLE_W){in_r_q[SAMPLE_W-1]}}, in_r_q} + tone_next;
  assign mix_l  = clamp(wide_l);
  assign mix_r  = clamp(wide_r);
`else
  // Low bits of the wide sum equal the sum of the low bits.
  assign mix_l = in_l_q + tone_next[SAMPLE_W-1:0];
  assign mix_r = in_r_q + tone_next[SAMPLE_W-1:0];
`endif

  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    tone_d          = tone_q;
    in_l_d          = in_l_q;
    in_r_d          = in_r_q;
    out_l_d         = out_l_q;
    out_r_d         = out_r_q;
    read_audio_in   = 1'b0;
    write_audio_out = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) snap_d[v] = snap_q[v];

    unique case (state_q)
      IDLE: begin
        if (audio_in_available && audio_out_allowed) begin
          in_l_d = pass_en ? left_channel_audio_in  : '0;
          in_r_d = pass_en ? right_channel_audio_in : '0;
          for (int v = 0; v < NUM_VOICES; v++) snap_d[v] = contrib[v];
          idx_d   = '0;
          tone_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        tone_d = tone_next;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_VOICES-1)) begin
          out_l_d = mix_l;
          out_r_d = mix_r;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Codec flags cannot drop without a pop/push, so strobe unconditionally.
        read_audio_in   = 1'b1;
        write_audio_out = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tone_q  <= '0;
      in_l_q  <= '0;
      in_r_q  <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      // NOTE: the snapshot array is reset too; it is register-based, not RAM.
      for (int v = 0; v < NUM_VOICES; v++) snap_q[v] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tone_q  <= tone_d;
      in_l_q  <= in_l_d;
      in_r_q  <= in_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      for (int v = 0; v < NUM_VOICES; v++) snap_q[v] <= snap_d[v];
    end
  end

  assign left_channel_audio_out  = out_l_q;
  assign right_channel_audio_out = out_r_q;

endmodule

// File: tb/tb_tone_voice_mixer.sv
// Directed, table-driven bench for tone_voice_mixer (NUM_VOICES=4).
module tb_tone_voice_mixer;

  localparam int NV = 4;
  localparam int PW = 19;
  localparam int AW = 24;
  localparam int SW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NV-1:0]    voice_en;
  logic [NV*PW-1:0] voice_period;
  logic [NV*AW-1:0] voice_amp;
  logic             pass_en;
  logic             avail;
  logic             allowed;
  logic [SW-1:0]    lin, rin;
  logic             read_audio_in, write_audio_out;
  logic [SW-1:0]    lout, rout;
  logic [NV-1:0]    voice_active;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  tone_voice_mixer #(
    .NUM_VOICES(NV), .PERIOD_W(PW), .AMP_W(AW), .SAMPLE_W(SW)
  ) dut (
    .CLOCK_50               (clk),
    .reset                  (rst),
    .voice_en               (voice_en),
    .voice_period           (voice_period),
    .voice_amp              (voice_amp),
    .pass_en                (pass_en),
    .audio_in_available     (avail),
    .audio_out_allowed      (allowed),
    .left_channel_audio_in  (lin),
    .right_channel_audio_in (rin),
    .read_audio_in          (read_audio_in),
    .write_audio_out        (write_audio_out),
    .left_channel_audio_out (lout),
    .right_channel_audio_out(rout),
    .voice_active           (voice_active)
  );

  typedef struct {
    logic [NV-1:0]    en;
    logic [NV*PW-1:0] period;
    logic [NV*AW-1:0] amp;
    logic             pass;
    logic [SW-1:0]    l, r, exp_l, exp_r;
    logic [NV-1:0]    exp_act;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [NV-1:0] en,
                              input int p0, input int p1, input int p2, input int p3,
                              input int a0, input int a1, input int a2, input int a3,
                              input logic pass, input logic [SW-1:0] l, input logic [SW-1:0] r,
                              input logic [SW-1:0] el, input logic [SW-1:0] er,
                              input logic [NV-1:0] act);
    mk.en      = en;
    mk.period  = {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    mk.amp     = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    mk.pass    = pass;
    mk.l       = l;
    mk.r       = r;
    mk.exp_l   = el;
    mk.exp_r   = er;
    mk.exp_act = act;
  endfunction

  // Called #1 after an edge with reset just released; handshake is seen w edges later.
  task automatic run_sample(input int w, input logic [SW-1:0] el, input logic [SW-1:0] er,
                            input string nm);
    int early;
    int lat;
    early = 0;
    for (int i = 0; i < w; i++) begin
      @(posedge clk); #1;
      if (write_audio_out || read_audio_in) early++;
    end
    check({nm, " no early strobe"}, early, 0);
    avail   = 1'b1;
    allowed = 1'b1;
    lat     = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (write_audio_out) begin
        lat = i;
        break;
      end
    end
    check({nm, " latency"}, lat, 5);
    check({nm, " read strobe"}, 32'(read_audio_in), 1);
    check({nm, " left"}, lout, el);
    check({nm, " right"}, rout, er);
    avail   = 1'b0;
    allowed = 1'b0;
    @(posedge clk); #1;
    check({nm, " strobe one cycle"}, 32'(write_audio_out), 0);
    check({nm, " left hold"}, lout, el);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit tone_pos [10] = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 1};
    int ns;
    int early;
    int ntog;
    int tog [3];
    logic prev;

    // Phase after 10 edges: p=9 ->1, p=4 ->0, p=2 ->1, p=1 ->1, p=1000 ->0.
    vecs[0] = mk(4'b0001, 9, 0, 0, 0, 1000, 0, 0, 0, 1'b0,
                 32'h12345678, 32'h0BADBEEF, 32'h000003E8, 32'h000003E8, 4'b0001);
    vecs[1] = mk(4'b0001, 4, 0, 0, 0, 1000, 0, 0, 0, 1'b1,
                 32'h00001388, 32'hFFFFFF38, 32'h00000FA0, 32'hFFFFFB50, 4'b0001);
    vecs[2] = mk(4'b1111, 9, 1, 2, 1000, 100, 20, 3, 7, 1'b1,
                 32'h00000000, 32'h000003E8, 32'h00000074, 32'h0000045C, 4'b1111);
    vecs[3] = mk(4'b1001, 9, 3, 5, 0, 1000, 50000, 60000, 70000, 1'b1,
                 32'hFFFFFFFF, 32'h00000001, 32'h000003E7, 32'h000003E9, 4'b0001);
`ifdef TONE_VOICE_MIXER_SAT_EN
    vecs[4] = mk(4'b1111, 9, 9, 9, 9, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 1'b1,
                 32'h7FFFFF00, 32'h00000000, 32'h7FFFFFFF, 32'h03FFFFFC, 4'b1111);
    vecs[5] = mk(4'b1111, 4, 4, 4, 4, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 1'b1,
                 32'h80000100, 32'h00000000, 32'h80000000, 32'hFC000004, 4'b1111);
`else
    vecs[4] = mk(4'b1111, 9, 9, 9, 9, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 1'b1,
                 32'h7FFFFF00, 32'h00000000, 32'h83FFFEFC, 32'h03FFFFFC, 4'b1111);
    vecs[5] = mk(4'b1111, 4, 4, 4, 4, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF, 1'b1,
                 32'h80000100, 32'h00000000, 32'h7C000104, 32'hFC000004, 4'b1111);
`endif
    vecs[6] = mk(4'b0111, 9, 4, 1, 3, 'hFFFFFF, 'hFFFFFF, 5, 9, 1'b0,
                 32'h0000007B, 32'h0000007B, 32'h00000005, 32'h00000005, 4'b0111);

    // Reset state, with the FIFO flags high to show reset blocks the FSM.
    rst = 1'b1; voice_en = '0; voice_period = '0; voice_amp = '0; pass_en = 1'b0;
    avail = 1'b1; allowed = 1'b1; lin = 32'h1; rin = 32'h2;
    repeat (3) @(posedge clk);
    #1;
    check("reset read", 32'(read_audio_in), 0);
    check("reset write", 32'(write_audio_out), 0);
    check("reset left", lout, 0);
    check("reset right", rout, 0);
    check("reset voice_active", 32'(voice_active), 0);

    for (int i = 0; i < 7; i++) begin
      rst = 1'b1;
      voice_en = vecs[i].en; voice_period = vecs[i].period; voice_amp = vecs[i].amp;
      pass_en = vecs[i].pass; lin = vecs[i].l; rin = vecs[i].r;
      avail = 1'b0; allowed = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d voice_active", i), 32'(voice_active), 32'(vecs[i].exp_act));
      rst = 1'b0;
      run_sample(10, vecs[i].exp_l, vecs[i].exp_r, $sformatf("vec%0d", i));
    end

    // Continuous single tone: snapshots at E0+6k see phase floor(6k/10)%2.
    rst = 1'b1; voice_en = 4'b0001; voice_period = '0; voice_amp = '0;
    voice_period[0 +: PW] = PW'(9); voice_amp[0 +: AW] = AW'(1000);
    pass_en = 1'b0; lin = 32'h55; rin = 32'h66; avail = 1'b1; allowed = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ns = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (write_audio_out) begin
        if (ns < 10) begin
          check($sformatf("tone strobe%0d edge", ns), i, 4 + 6*ns);
          check($sformatf("tone strobe%0d left", ns), lout,
                tone_pos[ns] ? 32'h000003E8 : 32'hFFFFFC18);
          check($sformatf("tone strobe%0d right", ns), rout,
                tone_pos[ns] ? 32'h000003E8 : 32'hFFFFFC18);
        end
        ns++;
      end
    end
    check("tone strobe count", ns, 13);
    avail = 1'b0; allowed = 1'b0;

    // Output FIFO full for 12 cycles, then allowed: strobe 5 cycles later.
    rst = 1'b1; pass_en = 1'b1; lin = 32'd100; rin = 32'd200; avail = 1'b1; allowed = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_sample(12, 32'd1100, 32'd1200, "handshake");

    // Period shrink at count 500: toggles on the next edge, then every 101.
    rst = 1'b1; voice_period[0 +: PW] = PW'(1000);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("shrink phase before", 32'(dut.g_voice[0].phase_q), 0);
    voice_period[0 +: PW] = PW'(100);
    prev = 1'b0; ntog = 0; tog = '{0, 0, 0};
    for (int e = 500; e <= 760; e++) begin
      @(posedge clk); #1;
      if (dut.g_voice[0].phase_q !== prev) begin
        if (ntog < 3) tog[ntog] = e;
        ntog++;
        prev = dut.g_voice[0].phase_q;
      end
    end
    check("shrink toggle count", ntog, 3);
    check("shrink toggle0 edge", tog[0], 500);
    check("shrink toggle1 edge", tog[1], 601);
    check("shrink toggle2 edge", tog[2], 702);

    // Reset during ACCUM of the second sample: no strobe, outputs cleared.
    rst = 1'b1; voice_period[0 +: PW] = PW'(9); pass_en = 1'b0;
    avail = 1'b1; allowed = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midreset prior left", lout, 32'hFFFFFC18);
    rst = 1'b1; avail = 1'b0; allowed = 1'b0;
    #1;
    check("midreset left cleared", lout, 0);
    check("midreset right cleared", rout, 0);
    early = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (write_audio_out) early++;
    end
    check("midreset no write", early, 0);
    rst = 1'b0;
    run_sample(10, 32'h000003E8, 32'h000003E8, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
